// File: rtl/uart_pkg.sv
// Shared byte constants, frame length and FSM state encoding for the UART frame responder.
// Optional macro UART_RESP_CHECKSUM_EN adds a trailing checksum byte to every frame.
package uart_pkg;

    localparam logic [7:0] SYNC_BYTE = 8'hA5;
    localparam logic [7:0] ACK_BYTE  = 8'h06;
    localparam logic [7:0] NAK_BYTE  = 8'h15;
    localparam logic [7:0] CMD_WRITE = 8'h01;
    localparam logic [7:0] CMD_READ  = 8'h02;

`ifdef UART_RESP_CHECKSUM_EN
    localparam int FRAME_LEN = 5;
`else
    localparam int FRAME_LEN = 4;
`endif

    typedef enum logic [2:0] {
        IDLE  = 3'd0,
        POP   = 3'd1,
        CAPT  = 3'd2,
        EXEC  = 3'd3,
        RESP0 = 3'd4,
        RESP1 = 3'd5
    } state_t;

endpackage

// File: rtl/uart_reg_file.sv
// Byte-wide register file: one synchronous write port, one combinational read port,
// all entries cleared by synchronous reset.
module uart_reg_file #(
    parameter int DEPTH = 16,
    parameter int AW    = 4
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          wr_en,
    input  logic [AW-1:0] wr_addr,
    input  logic [7:0]    wr_data,
    input  logic [AW-1:0] rd_addr,
    output logic [7:0]    rd_data
);

    logic [7:0] regs [DEPTH];

    always_ff @(posedge clk) begin
        if (reset) begin
            for (int i = 0; i < DEPTH; i++) begin
                regs[i] <= 8'h00;
            end
        end else if (wr_en) begin
            regs[wr_addr] <= wr_data;
        end
    end

    assign rd_data = regs[rd_addr];

endmodule

// File: rtl/uart_frame_responder.sv
// Parses SYNC/CMD/ADDR/DATA frames from an RX FIFO, executes register reads/writes and
// pushes ACK/NAK (+ read data) to a TX FIFO. Macro UART_RESP_CHECKSUM_EN adds a CHK byte.
//
// state | meaning
// IDLE  | wait for an RX byte; count the inter-byte gap while a frame is pending
// POP   | rx_fifo_rd_en high for this single cycle
// CAPT  | FIFO data valid; store byte and advance the byte index
// EXEC  | validate frame, commit write, prepare response bytes
// RESP0 | push ACK/NAK once the TX FIFO has room
// RESP1 | push read data once the TX FIFO has room
module uart_frame_responder
    import uart_pkg::*;
#(
    parameter int REG_DEPTH      = 16,
    parameter int TIMEOUT_CYCLES = 50000
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       rx_fifo_empty,
    input  logic [7:0] rx_fifo_data,
    output logic       rx_fifo_rd_en,
    input  logic       tx_fifo_full,
    output logic       tx_fifo_wr_en,
    output logic [7:0] tx_fifo_data,
    output logic       reg_wr_pulse,
    output logic [7:0] reg_wr_addr,
    output logic [7:0] reg_wr_data,
    output logic       busy
);

    localparam int          AW       = (REG_DEPTH > 1) ? $clog2(REG_DEPTH) : 1;
    localparam int          TW       = $clog2(TIMEOUT_CYCLES + 1);
    localparam logic [2:0]  LAST_IDX = 3'(FRAME_LEN - 1);
    localparam logic [TW-1:0] GAP_MAX = TW'(TIMEOUT_CYCLES);

    state_t        state;
    logic [2:0]    byte_idx;
    logic [TW-1:0] gap_cnt;
    logic [7:0]    frame_cmd;
    logic [7:0]    frame_addr;
    logic [7:0]    frame_data;
    logic [7:0]    resp0_byte;
    logic [7:0]    resp1_byte;
    logic          resp1_pending;
    logic [7:0]    rd_data;
    logic          cmd_ok;
    logic          addr_ok;
    logic          chk_ok;
    logic          frame_ok;
    logic          reg_we;

`ifdef UART_RESP_CHECKSUM_EN
    logic [7:0]    frame_chk;
    assign chk_ok = (frame_chk == (frame_cmd ^ frame_addr ^ frame_data));
`else
    assign chk_ok = 1'b1;
`endif

    assign cmd_ok   = (frame_cmd == CMD_WRITE) || (frame_cmd == CMD_READ);
    assign addr_ok  = (32'(frame_addr) < REG_DEPTH);
    assign frame_ok = cmd_ok && addr_ok && chk_ok;
    assign reg_we   = (state == EXEC) && frame_ok && (frame_cmd == CMD_WRITE);
    assign busy     = (state != IDLE);

    uart_reg_file #(
        .DEPTH (REG_DEPTH),
        .AW    (AW)
    ) u_reg_file (
        .clk     (clk),
        .reset   (reset),
        .wr_en   (reg_we),
        .wr_addr (frame_addr[AW-1:0]),
        .wr_data (frame_data),
        .rd_addr (frame_addr[AW-1:0]),
        .rd_data (rd_data)
    );

    always_ff @(posedge clk) begin
        if (reset) begin
            state         <= IDLE;
            byte_idx      <= 3'd0;
            gap_cnt       <= '0;
            frame_cmd     <= 8'h00;
            frame_addr    <= 8'h00;
            frame_data    <= 8'h00;
`ifdef UART_RESP_CHECKSUM_EN
            frame_chk     <= 8'h00;
`endif
            resp0_byte    <= 8'h00;
            resp1_byte    <= 8'h00;
            resp1_pending <= 1'b0;
            rx_fifo_rd_en <= 1'b0;
            tx_fifo_wr_en <= 1'b0;
            tx_fifo_data  <= 8'h00;
            reg_wr_pulse  <= 1'b0;
            reg_wr_addr   <= 8'h00;
            reg_wr_data   <= 8'h00;
        end else begin
            rx_fifo_rd_en <= 1'b0;
            tx_fifo_wr_en <= 1'b0;
            reg_wr_pulse  <= 1'b0;

            case (state)
                IDLE: begin
                    if (!rx_fifo_empty) begin
                        state         <= POP;
                        rx_fifo_rd_en <= 1'b1;
                    end else if (byte_idx != 3'd0) begin
                        // A stalled frame is abandoned silently once the gap overruns
                        if (gap_cnt == GAP_MAX) begin
                            byte_idx <= 3'd0;
                            gap_cnt  <= '0;
                        end else begin
                            gap_cnt <= gap_cnt + TW'(1);
                        end
                    end
                end

                POP: begin
                    state <= CAPT;
                end

                CAPT: begin
                    gap_cnt <= '0;
                    state   <= IDLE;
                    case (byte_idx)
                        3'd0: begin
                            if (rx_fifo_data == SYNC_BYTE) begin
                                byte_idx <= 3'd1;
                            end
                        end
                        3'd1: frame_cmd  <= rx_fifo_data;
                        3'd2: frame_addr <= rx_fifo_data;
                        3'd3: frame_data <= rx_fifo_data;
`ifdef UART_RESP_CHECKSUM_EN
                        3'd4: frame_chk  <= rx_fifo_data;
`endif
                        default: ;
                    endcase
                    if (byte_idx != 3'd0) begin
                        if (byte_idx == LAST_IDX) begin
                            byte_idx <= 3'd0;
                            state    <= EXEC;
                        end else begin
                            byte_idx <= byte_idx + 3'd1;
                        end
                    end
                end

                EXEC: begin
                    state      <= RESP0;
                    resp1_byte <= rd_data;
                    if (frame_ok) begin
                        resp0_byte    <= ACK_BYTE;
                        resp1_pending <= (frame_cmd == CMD_READ);
                        if (frame_cmd == CMD_WRITE) begin
                            reg_wr_pulse <= 1'b1;
                            reg_wr_addr  <= frame_addr;
                            reg_wr_data  <= frame_data;
                        end
                    end else begin
                        resp0_byte    <= NAK_BYTE;
                        resp1_pending <= 1'b0;
                    end
                end

                RESP0: begin
                    if (!tx_fifo_full) begin
                        tx_fifo_wr_en <= 1'b1;
                        tx_fifo_data  <= resp0_byte;
                        state         <= resp1_pending ? RESP1 : IDLE;
                    end
                end

                RESP1: begin
                    // Skip the cycle of the previous push so the full flag has caught up
                    if (!tx_fifo_full && !tx_fifo_wr_en) begin
                        tx_fifo_wr_en <= 1'b1;
                        tx_fifo_data  <= resp1_byte;
                        state         <= IDLE;
                    end
                end

                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_uart_frame_responder.sv
// Scoreboard bench for uart_frame_responder: RX FIFO model feeds frames, expected TX bytes
// and register writes are queued at stimulus time and compared as the DUT produces them.
module tb_uart_frame_responder;

    localparam int REG_DEPTH = 16;
    localparam int TIMEOUT   = 40;

    logic       clk = 1'b0;
    logic       reset;
    logic       rx_fifo_empty;
    logic [7:0] rx_fifo_data = 8'h00;
    logic       rx_fifo_rd_en;
    logic       tx_fifo_full;
    logic       tx_fifo_wr_en;
    logic [7:0] tx_fifo_data;
    logic       reg_wr_pulse;
    logic [7:0] reg_wr_addr;
    logic [7:0] reg_wr_data;
    logic       busy;

    always #5 clk = ~clk;

    uart_frame_responder #(
        .REG_DEPTH      (REG_DEPTH),
        .TIMEOUT_CYCLES (TIMEOUT)
    ) dut (
        .clk           (clk),
        .reset         (reset),
        .rx_fifo_empty (rx_fifo_empty),
        .rx_fifo_data  (rx_fifo_data),
        .rx_fifo_rd_en (rx_fifo_rd_en),
        .tx_fifo_full  (tx_fifo_full),
        .tx_fifo_wr_en (tx_fifo_wr_en),
        .tx_fifo_data  (tx_fifo_data),
        .reg_wr_pulse  (reg_wr_pulse),
        .reg_wr_addr   (reg_wr_addr),
        .reg_wr_data   (reg_wr_data),
        .busy          (busy)
    );

    // RX FIFO model: standard mode, dout updates the cycle after rd_en
    logic [7:0] rx_buf [0:1023];
    int         rx_wp = 0;
    int         rx_rp = 0;

    assign rx_fifo_empty = (rx_wp == rx_rp);

    always @(posedge clk) begin
        if (reset) begin
            rx_rp <= rx_wp;
        end else if (rx_fifo_rd_en && (rx_wp != rx_rp)) begin
            rx_fifo_data <= rx_buf[rx_rp % 1024];
            rx_rp        <= rx_rp + 1;
        end
    end

    logic [7:0]  tx_exp [$];
    logic [15:0] wr_exp [$];
    logic [7:0]  model_regs [256];
    logic [7:0]  tx_item;
    logic [15:0] wr_item;
    int          n_checks = 0;
    int          n_fail   = 0;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    always @(negedge clk) begin
        if (rx_fifo_rd_en) begin
            check_eq("rd_while_empty", 32'(rx_fifo_empty), 32'd0);
        end
        if (tx_fifo_wr_en) begin
            check_eq("tx_when_full", 32'(tx_fifo_full), 32'd0);
            check_eq("tx_expected", 32'(tx_exp.size() != 0), 32'd1);
            if (tx_exp.size() != 0) begin
                tx_item = tx_exp.pop_front();
                check_eq("tx_byte", 32'(tx_fifo_data), 32'(tx_item));
            end
        end
        if (reg_wr_pulse) begin
            check_eq("wr_expected", 32'(wr_exp.size() != 0), 32'd1);
            if (wr_exp.size() != 0) begin
                wr_item = wr_exp.pop_front();
                check_eq("wr_addr", 32'(reg_wr_addr), 32'(wr_item[15:8]));
                check_eq("wr_data", 32'(reg_wr_data), 32'(wr_item[7:0]));
            end
        end
    end

    task automatic push_byte(input logic [7:0] b);
        @(posedge clk);
        #1;
        rx_buf[rx_wp % 1024] = b;
        rx_wp = rx_wp + 1;
    endtask

    task automatic expect_frame(input logic [7:0] cmd, input logic [7:0] addr,
                                input logic [7:0] data, input bit chk_ok);
        if (chk_ok && (32'(addr) < REG_DEPTH) && cmd == 8'h01) begin
            tx_exp.push_back(8'h06);
            wr_exp.push_back({addr, data});
            model_regs[addr] = data;
        end else if (chk_ok && (32'(addr) < REG_DEPTH) && cmd == 8'h02) begin
            tx_exp.push_back(8'h06);
            tx_exp.push_back(model_regs[addr]);
        end else begin
            tx_exp.push_back(8'h15);
        end
    endtask

    task automatic send_raw(input logic [7:0] cmd, input logic [7:0] addr, input logic [7:0] data);
        push_byte(8'hA5);
        push_byte(cmd);
        push_byte(addr);
        push_byte(data);
    endtask

    task automatic send_frame(input logic [7:0] cmd, input logic [7:0] addr, input logic [7:0] data);
        expect_frame(cmd, addr, data, 1'b1);
        send_raw(cmd, addr, data);
`ifdef UART_RESP_CHECKSUM_EN
        push_byte(cmd ^ addr ^ data);
`endif
    endtask

    task automatic drain(input string tag);
        int n;
        n = 0;
        while ((rx_wp != rx_rp || busy || tx_exp.size() != 0 || wr_exp.size() != 0) && n < 3000) begin
            @(negedge clk);
            n++;
        end
        check_eq(tag, 32'(n < 3000), 32'd1);
        repeat (5) @(negedge clk);
    endtask

    task automatic do_reset();
        @(posedge clk);
        #1;
        reset = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        reset = 1'b0;
        for (int i = 0; i < 256; i++) model_regs[i] = 8'h00;
    endtask

    initial begin
        reset        = 1'b1;
        tx_fifo_full = 1'b0;
        for (int i = 0; i < 256; i++) model_regs[i] = 8'h00;
        repeat (3) @(posedge clk);
        @(negedge clk);
        check_eq("rst_busy", 32'(busy), 32'd0);
        check_eq("rst_rd_en", 32'(rx_fifo_rd_en), 32'd0);
        check_eq("rst_wr_en", 32'(tx_fifo_wr_en), 32'd0);
        check_eq("rst_tx_data", 32'(tx_fifo_data), 32'd0);
        check_eq("rst_pulse", 32'(reg_wr_pulse), 32'd0);
        check_eq("rst_wr_addr", 32'(reg_wr_addr), 32'd0);
        check_eq("rst_wr_data", 32'(reg_wr_data), 32'd0);
        @(posedge clk);
        #1;
        reset = 1'b0;

        // write then read back
        send_frame(8'h01, 8'h03, 8'h5C);
        drain("drain_write");
        send_frame(8'h02, 8'h03, 8'h00);
        drain("drain_read");

        // unknown command, out-of-range write and read
        send_frame(8'h07, 8'h00, 8'h00);
        send_frame(8'h01, 8'h10, 8'hAA);
        send_frame(8'h02, 8'h10, 8'h00);
        drain("drain_nak");

        // leading garbage discarded at index 0
        push_byte(8'h00);
        push_byte(8'hFF);
        send_frame(8'h01, 8'h04, 8'h77);
        drain("drain_garbage");

        // SYNC value inside a frame is plain data, top register boundary
        send_frame(8'h01, 8'h0F, 8'hA5);
        send_frame(8'h02, 8'h0F, 8'h00);
        drain("drain_sync_data");

        // stalled partial frame is dropped after the gap
        push_byte(8'hA5);
        push_byte(8'h01);
        repeat (TIMEOUT + 20) @(negedge clk);
        send_frame(8'h01, 8'h02, 8'h33);
        drain("drain_timeout");
        send_frame(8'h02, 8'h02, 8'h00);
        drain("drain_timeout_rd");

`ifdef UART_RESP_CHECKSUM_EN
        expect_frame(8'h01, 8'h02, 8'h33, 1'b1);
        send_raw(8'h01, 8'h02, 8'h33);
        push_byte(8'h30);
        expect_frame(8'h01, 8'h02, 8'h33, 1'b0);
        send_raw(8'h01, 8'h02, 8'h33);
        push_byte(8'h31);
        expect_frame(8'h01, 8'h02, 8'h55, 1'b0);
        send_raw(8'h01, 8'h02, 8'h55);
        push_byte(8'h00);
        send_frame(8'h02, 8'h02, 8'h00);
        drain("drain_chk");
`endif

        // TX FIFO full during a read response
        @(posedge clk);
        #1;
        tx_fifo_full = 1'b1;
        send_frame(8'h02, 8'h02, 8'h00);
        repeat (20) @(negedge clk);
        check_eq("stall_busy", 32'(busy), 32'd1);
        check_eq("stall_pending", 32'(tx_exp.size()), 32'd2);
        repeat (20) @(negedge clk);
        @(posedge clk);
        #1;
        tx_fifo_full = 1'b0;
        drain("drain_stall");

        // reset mid-response: nothing emitted, registers cleared
        @(posedge clk);
        #1;
        tx_fifo_full = 1'b1;
        send_raw(8'h02, 8'h03, 8'h00);
        repeat (30) @(negedge clk);
        do_reset();
        tx_fifo_full = 1'b0;
        repeat (20) @(negedge clk);
        send_frame(8'h02, 8'h02, 8'h00);
        drain("drain_rst_resp");

        // reset mid-frame: partial frame dropped, no write
        send_frame(8'h01, 8'h03, 8'h11);
        drain("drain_pre_rst");
        push_byte(8'hA5);
        push_byte(8'h01);
        push_byte(8'h03);
        repeat (15) @(negedge clk);
        do_reset();
        send_frame(8'h02, 8'h03, 8'h00);
        drain("drain_rst_frame");

        check_eq("tx_left", 32'(tx_exp.size()), 32'd0);
        check_eq("wr_left", 32'(wr_exp.size()), 32'd0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
